// File: rtl/ola_out_if.sv
// Bus interface for the ola_out overlap-add stage: IFFT ingest, DAC readout and status.
interface ola_out_if #(
    parameter int unsigned WIDTH = 32
);
    logic             data_in_en;
    logic [WIDTH-1:0] data_in_re;
    logic [WIDTH-1:0] data_in_im;
    logic             sample_req;
    logic             clr_flags;
    logic             data_out_en;
    logic [WIDTH-1:0] data_out;
    logic             underrun;
    logic             overrun;
    logic [1:0]       banks_ready;

    // Upstream/DAC side driving the stage
    modport master (
        output data_in_en, data_in_re, data_in_im, sample_req, clr_flags,
        input  data_out_en, data_out, underrun, overrun, banks_ready
    );

    // The overlap-add stage itself
    modport slave (
        input  data_in_en, data_in_re, data_in_im, sample_req, clr_flags,
        output data_out_en, data_out, underrun, overrun, banks_ready
    );
endinterface

// File: rtl/ola_out.sv
// Overlap-add output stage behind the 64-point IFFT.
// Adds each frame's first half to the previous frame's stored second half,
// buffers the results in a ping-pong bank pair and releases one sample per DAC request.
// Optional macro OLA_SAT_EN: saturating overlap sum plus +/-1.0 output clamp.
module ola_out #(
    parameter int unsigned N     = 64,
    parameter int unsigned HOP   = 32,
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    ola_out_if.slave  bus
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned AW = $clog2(HOP);
    localparam logic [IW-1:0] LAST_LO  = IW'(HOP - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [AW-1:0] LAST_RD  = AW'(HOP - 1);
`ifdef OLA_SAT_EN
    localparam int unsigned FRAC = WIDTH - 8;
    localparam logic signed [WIDTH-1:0] POS_ONE = WIDTH'(1) << FRAC;
    localparam logic signed [WIDTH-1:0] NEG_ONE = -POS_ONE;
`endif

    typedef enum logic [1:0] {FILL_LO, FILL_HI, DROP} state_t;

    state_t           state, state_d;
    logic [IW-1:0]    idx, idx_d;
    logic             bank_we_c, tail_we_c, fill_c, free_c;
    logic             rd_ok_c, underrun_ev_c, overrun_ev_c;
    logic             wptr, rptr;
    logic [AW-1:0]    ridx;
    logic [AW-1:0]    widx;
    logic [WIDTH-1:0] bank_mem [2*HOP];
    logic [WIDTH-1:0] tail_mem [HOP];
    logic [WIDTH:0]   sum_wide_c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] rd_raw_c, rd_data_c;
    logic             unused_im;

    assign widx      = idx[AW-1:0];
    assign unused_im = ^bus.data_in_im;

    // Ingest FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL_LO;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    // Ingest next-state: first half summed into the write bank, second half to tail, or frame dropped
    always_comb begin
        state_d      = state;
        idx_d        = idx;
        bank_we_c    = 1'b0;
        tail_we_c    = 1'b0;
        fill_c       = 1'b0;
        overrun_ev_c = 1'b0;
        if (bus.data_in_en) begin
            idx_d = idx + IW'(1);
            unique case (state)
                FILL_LO: begin
                    if (idx == '0 && bus.banks_ready == 2'd2) begin
                        overrun_ev_c = 1'b1;
                        state_d      = DROP;
                    end else begin
                        bank_we_c = 1'b1;
                        if (idx == LAST_LO) begin
                            fill_c  = 1'b1;
                            state_d = FILL_HI;
                        end
                    end
                end
                FILL_HI: begin
                    tail_we_c = 1'b1;
                    if (idx == LAST_IDX) state_d = FILL_LO;
                end
                DROP: begin
                    if (idx == LAST_IDX) state_d = FILL_LO;
                end
                default: state_d = FILL_LO;
            endcase
        end
    end

    // Overlap sum, wrapped or saturated to the sample range
    always_comb begin
        sum_wide_c = {bus.data_in_re[WIDTH-1], bus.data_in_re}
                   + {tail_mem[widx][WIDTH-1], tail_mem[widx]};
        sum_c      = sum_wide_c[WIDTH-1:0];
`ifdef OLA_SAT_EN
        if (sum_wide_c[WIDTH] != sum_wide_c[WIDTH-1]) begin
            sum_c = sum_wide_c[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Readout decode and optional DAC-protection clamp
    always_comb begin
        rd_ok_c       = bus.sample_req && (bus.banks_ready != 2'd0);
        underrun_ev_c = bus.sample_req && (bus.banks_ready == 2'd0);
        free_c        = rd_ok_c && (ridx == LAST_RD);
        rd_raw_c      = bank_mem[{rptr, ridx}];
        rd_data_c     = rd_raw_c;
`ifdef OLA_SAT_EN
        if ($signed(rd_raw_c) > POS_ONE) begin
            rd_data_c = POS_ONE;
        end else if ($signed(rd_raw_c) < NEG_ONE) begin
            rd_data_c = NEG_ONE;
        end
`endif
    end

    // Bank memory write port
    always_ff @(posedge clk) begin
        if (bank_we_c) bank_mem[{wptr, widx}] <= sum_c;
    end

    // Tail memory: cleared on reset so the first frame overlaps with silence
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(HOP); i++) tail_mem[i] <= '0;
        end else if (tail_we_c) begin
            tail_mem[widx] <= bus.data_in_re;
        end
    end

    // Bank pointers, fill count, readout and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr            <= 1'b0;
            rptr            <= 1'b0;
            ridx            <= '0;
            bus.banks_ready <= 2'd0;
            bus.data_out_en <= 1'b0;
            bus.data_out    <= '0;
            bus.underrun    <= 1'b0;
            bus.overrun     <= 1'b0;
        end else begin
            if (fill_c) wptr <= ~wptr;
            if (free_c) rptr <= ~rptr;
            if (rd_ok_c) ridx <= ridx + AW'(1);
            unique case ({fill_c, free_c})
                2'b10:   bus.banks_ready <= bus.banks_ready + 2'd1;
                2'b01:   bus.banks_ready <= bus.banks_ready - 2'd1;
                default: bus.banks_ready <= bus.banks_ready;
            endcase
            bus.data_out_en <= bus.sample_req;
            if (rd_ok_c) begin
                bus.data_out <= rd_data_c;
            end else if (bus.sample_req) begin
                bus.data_out <= '0;
            end
            bus.underrun <= underrun_ev_c | (bus.underrun & ~bus.clr_flags);
            bus.overrun  <= overrun_ev_c  | (bus.overrun  & ~bus.clr_flags);
        end
    end
endmodule

// File: tb/tb_ola_out.sv
// Directed bench for ola_out with a scoreboard of expected output samples.
module tb_ola_out;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    ola_out_if #(.WIDTH(32)) bus ();

    ola_out #(.N(64), .HOP(32), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [31:0] m_tail [32];
    int          m_ready;
    int          m_rcnt;
    bit          m_underrun;
    bit          m_overrun;

    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef OLA_SAT_EN
        if (s > 64'sh7FFFFFFF) s = 64'sh7FFFFFFF;
        else if (s < -64'sh80000000) s = -64'sh80000000;
        if (s > 64'sh01000000) s = 64'sh01000000;
        else if (s < -64'sh01000000) s = -64'sh01000000;
`endif
        return s[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_ready"},    32'(bus.banks_ready), 32'(m_ready));
        check({tag, "_underrun"}, 32'(bus.underrun),    32'(m_underrun));
        check({tag, "_overrun"},  32'(bus.overrun),     32'(m_overrun));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b1;
        bus.data_in_en  = 1'b0;
        bus.data_in_re  = '0;
        bus.data_in_im  = '0;
        bus.sample_req  = 1'b0;
        bus.clr_flags   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) m_tail[i] = '0;
        m_ready    = 0;
        m_rcnt     = 0;
        m_underrun = 0;
        m_overrun  = 0;
    endtask

    task automatic send_frame(input logic [31:0] base, input logic [31:0] step, input bit gaps);
        logic [31:0] v;
        bit drop;
        drop = (m_ready == 2);
        if (drop) m_overrun = 1;
        for (int i = 0; i < 64; i++) begin
            v = base + step * 32'(i);
            @(negedge clk);
            bus.data_in_en = 1'b1;
            bus.data_in_re = v;
            bus.data_in_im = $urandom;
            if (!drop) begin
                if (i < 32) exp_q.push_back(model_sum(v, m_tail[i]));
                else m_tail[i-32] = v;
            end
            if (gaps && (i % 5 == 2)) begin
                @(negedge clk);
                bus.data_in_en = 1'b0;
                bus.data_in_re = $urandom;
            end
        end
        @(negedge clk);
        bus.data_in_en = 1'b0;
        if (!drop) m_ready++;
    endtask

    task automatic send_partial(input logic [31:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.data_in_en = 1'b1;
            bus.data_in_re = val;
        end
        @(negedge clk);
        bus.data_in_en = 1'b0;
    endtask

    // Back-to-back sample requests; each output checked one cycle after its request
    task automatic drain(input int n, input string tag);
        logic [31:0] exp;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.sample_req = 1'b1;
            if (m_ready > 0) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                m_rcnt++;
                if (m_rcnt == 32) begin
                    m_rcnt = 0;
                    m_ready--;
                end
            end else begin
                exp = '0;
                m_underrun = 1;
            end
            @(posedge clk);
            #1;
            check($sformatf("%s_en[%0d]", tag, k), 32'(bus.data_out_en), 32'd1);
            check($sformatf("%s_data[%0d]", tag, k), bus.data_out, exp);
        end
        @(negedge clk);
        bus.sample_req = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_en_drop"}, 32'(bus.data_out_en), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.data_in_en = 1'b0;
        bus.data_in_re = '0;
        bus.data_in_im = '0;
        bus.sample_req = 1'b0;
        bus.clr_flags  = 1'b0;

        // Reset state
        do_reset();
        check("rst_data", bus.data_out, 32'd0);
        check("rst_en", 32'(bus.data_out_en), 32'd0);
        check_status("rst");

        // Underrun with no frame, then clear racing a second underrun, then plain clear
        drain(1, "under");
        @(negedge clk);
        check_status("under");
        bus.clr_flags  = 1'b1;
        bus.sample_req = 1'b1;
        @(posedge clk);
        #1;
        check("clr_race_underrun", 32'(bus.underrun), 32'd1);
        check("clr_race_data", bus.data_out, 32'd0);
        @(negedge clk);
        bus.sample_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.clr_flags = 1'b0;
        m_underrun    = 0;
        @(negedge clk);
        check_status("clr");

        // Single frame over an empty tail
        send_frame(32'h0010_0000, 32'h0, 1'b0);
        check_status("one_frame");
        drain(32, "one");
        check_status("one_drained");

        // Two frames: second bank carries the overlap
        do_reset();
        send_frame(32'h0010_0000, 32'h0, 1'b0);
        send_frame(32'h0010_0000, 32'h0, 1'b0);
        check_status("two_frames");
        drain(64, "two");
        check_status("two_drained");

        // Three frames with gaps: third is dropped, tail keeps frame 2
        do_reset();
        send_frame(32'h0001_0000, 32'h0000_1000, 1'b1);
        send_frame(32'hFFF0_0000, 32'h0000_2000, 1'b1);
        send_frame(32'h0030_0000, 32'hFFFF_0000, 1'b1);
        check_status("three_frames");
        drain(64, "three");
        check_status("three_drained");
        send_frame(32'h0005_0000, 32'h0000_0100, 1'b0);
        drain(32, "after_drop");
        check_status("after_drop");

        // Bank fill and bank free on the same edge
        do_reset();
        send_frame(32'h0040_0000, 32'h0000_0010, 1'b0);
        fork
            send_frame(32'h0002_0000, 32'h0000_0020, 1'b0);
            drain(32, "sim_a");
        join
        @(negedge clk);
        check_status("simul");
        drain(32, "sim_b");
        check_status("simul_drained");

        // Overflow of the overlap sum in both directions
        do_reset();
        send_frame(32'h7F00_0000, 32'h0, 1'b0);
        send_frame(32'h7F00_0000, 32'h0, 1'b0);
        drain(64, "ovf_pos");
        send_frame(32'h8100_0000, 32'h0, 1'b0);
        drain(32, "ovf_mid");
        send_frame(32'h8100_0000, 32'h0, 1'b0);
        drain(32, "ovf_neg");
        check_status("ovf");

        // Reset mid-frame discards the partial frame and clears the tail
        do_reset();
        send_partial(32'h0050_0000, 40);
        do_reset();
        check_status("midrst");
        send_frame(32'h0001_0000, 32'h0, 1'b0);
        drain(32, "midrst");
        check_status("midrst_drained");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
